// File: rtl/pc_unit.sv
// ============================================================================
// pc_unit : program counter with internal next-PC selection, exception entry
//           (EPC capture), single-level handler state and JR alignment check.
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_unit #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pc_wr,
  input  logic [2:0]       i_npc_sel,
  input  logic             i_br_taken,
  input  logic [15:0]      i_imm16,
  input  logic [25:0]      i_target26,
  input  logic [WIDTH-1:0] i_rs_val,
  input  logic             i_exc_req,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc4,
  output logic [WIDTH-1:0] o_epc,
  output logic             o_in_exc,
  output logic             o_exc_lost,
  output logic             o_addr_err
);

  localparam logic [2:0] c_SEL_SEQ  = 3'd0;
  localparam logic [2:0] c_SEL_BR   = 3'd1;
  localparam logic [2:0] c_SEL_J    = 3'd2;
  localparam logic [2:0] c_SEL_JR   = 3'd3;
  localparam logic [2:0] c_SEL_ERET = 3'd4;

  localparam logic [0:0] c_ST_NORMAL  = 1'b0;
  localparam logic [0:0] c_ST_HANDLER = 1'b1;

  localparam logic [WIDTH-1:0] c_RESET_PC = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] c_EXC_PC   = WIDTH'(EXC_VEC);
  localparam logic [WIDTH-1:0] c_FOUR     = WIDTH'(4);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic             r_exc_lost;
  logic             r_addr_err;

  logic [WIDTH-1:0] w_pc4;
  logic [WIDTH-1:0] w_br_off;
  logic [WIDTH-1:0] w_br_tgt;
  logic [WIDTH-1:0] w_j_tgt;
  logic [WIDTH-1:0] w_pc_nxt;
  logic             w_in_handler;
  logic             w_jr_mis;
  logic             w_ee;
  logic             w_take_exc;
  logic             w_eret_ok;

  // --------------------------------------------------------------------------
  // Target computation and exception qualification
  // --------------------------------------------------------------------------
  assign w_pc4        = r_pc + c_FOUR;
  assign w_br_off     = {{(WIDTH-18){i_imm16[15]}}, i_imm16, 2'b00};
  assign w_br_tgt     = w_pc4 + w_br_off;
  assign w_j_tgt      = {w_pc4[WIDTH-1:28], i_target26, 2'b00};
  assign w_in_handler = (r_state == c_ST_HANDLER);

  assign w_jr_mis   = i_pc_wr && (i_npc_sel == c_SEL_JR) && (i_rs_val[1:0] != 2'b00);
  assign w_ee       = i_exc_req || w_jr_mis;
  assign w_take_exc = w_ee && !w_in_handler;
  assign w_eret_ok  = i_pc_wr && (i_npc_sel == c_SEL_ERET) && w_in_handler;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_NORMAL: begin
        if (w_take_exc) begin
          w_state_nxt = c_ST_HANDLER;
        end
      end
      c_ST_HANDLER: begin
        // A lone exc_req in the handler does not block a legitimate ERET.
        if (w_eret_ok) begin
          w_state_nxt = c_ST_NORMAL;
        end
      end
      default: w_state_nxt = c_ST_NORMAL;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_in_exc = (r_state == c_ST_HANDLER);
  end

  // --------------------------------------------------------------------------
  // Next-PC selection
  // --------------------------------------------------------------------------
  always_comb begin
    w_pc_nxt = r_pc;
    if (w_take_exc) begin
      w_pc_nxt = c_EXC_PC;
    end else if (i_pc_wr && !w_jr_mis) begin
      case (i_npc_sel)
        c_SEL_SEQ:  w_pc_nxt = w_pc4;
        c_SEL_BR:   w_pc_nxt = i_br_taken ? w_br_tgt : w_pc4;
        c_SEL_J:    w_pc_nxt = w_j_tgt;
        c_SEL_JR:   w_pc_nxt = i_rs_val;
        c_SEL_ERET: w_pc_nxt = w_in_handler ? r_epc : w_pc4;
        default:    w_pc_nxt = w_pc4;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= c_RESET_PC;
      r_epc      <= '0;
      r_exc_lost <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_addr_err <= w_jr_mis;
      if (w_take_exc) begin
        r_epc <= r_pc;
      end
      if (w_ee && w_in_handler) begin
        r_exc_lost <= 1'b1;
      end
    end
  end

  assign o_pc       = r_pc;
  assign o_pc4      = w_pc4;
  assign o_epc      = r_epc;
  assign o_exc_lost = r_exc_lost;
  assign o_addr_err = r_addr_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// tb_pc_unit : directed self-checking bench for pc_unit with a per-cycle model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_wr;
  logic [2:0]  npc_sel;
  logic        br_taken;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] rs_val;
  logic        exc_req;
  logic [31:0] pc, pc4, epc;
  logic        in_exc, exc_lost, addr_err;

  logic        pc_wr64;
  logic [2:0]  sel64;
  logic [63:0] rs64;
  logic [63:0] pc_64, pc4_64, epc_64;
  logic        in_exc64, lost64, aerr64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_pc_wr(pc_wr), .i_npc_sel(npc_sel),
    .i_br_taken(br_taken), .i_imm16(imm16), .i_target26(target26),
    .i_rs_val(rs_val), .i_exc_req(exc_req),
    .o_pc(pc), .o_pc4(pc4), .o_epc(epc), .o_in_exc(in_exc),
    .o_exc_lost(exc_lost), .o_addr_err(addr_err)
  );

  pc_unit #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .i_pc_wr(pc_wr64), .i_npc_sel(sel64),
    .i_br_taken(1'b0), .i_imm16(16'h0), .i_target26(26'h0),
    .i_rs_val(rs64), .i_exc_req(1'b0),
    .o_pc(pc_64), .o_pc4(pc4_64), .o_epc(epc_64), .o_in_exc(in_exc64),
    .o_exc_lost(lost64), .o_addr_err(aerr64)
  );

  // Reference model: architectural state updated from the rules, one edge at a time.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        in_exc;
    logic        lost;
    logic        aerr;
  } ms_t;

  ms_t m;
  logic m_valid = 1'b0;

  function automatic ms_t model_next(ms_t s, logic r, logic wr, logic [2:0] sel,
                                     logic bt, logic [15:0] im, logic [25:0] tg,
                                     logic [31:0] rs, logic ex);
    ms_t n;
    logic jr_bad;
    logic ee;
    logic [31:0] seq;
    n = s;
    if (r) begin
      n.pc = 32'h3000; n.epc = 32'h0; n.in_exc = 1'b0; n.lost = 1'b0; n.aerr = 1'b0;
      return n;
    end
    jr_bad = wr && (sel == 3'd3) && (rs[1:0] != 2'b00);
    ee     = ex || jr_bad;
    seq    = s.pc + 32'd4;
    n.aerr = jr_bad;
    if (ee && !s.in_exc) begin
      n.pc = 32'h4180; n.epc = s.pc; n.in_exc = 1'b1;
    end else begin
      if (ee) n.lost = 1'b1;
      if (wr && !jr_bad) begin
        case (sel)
          3'd1: n.pc = bt ? seq + 32'($signed(im)) * 32'sd4 : seq;
          3'd2: n.pc = {seq[31:28], tg, 2'b00};
          3'd3: n.pc = rs;
          3'd4: if (s.in_exc) begin n.pc = s.epc; n.in_exc = 1'b0; end
                else n.pc = seq;
          default: n.pc = seq;
        endcase
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m <= model_next(m, rst, pc_wr, npc_sel, br_taken, imm16, target26, rs_val, exc_req);
    if (rst) m_valid <= 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_pc",       64'(pc),       64'(m.pc));
      chk("m_pc4",      64'(pc4),      64'(m.pc + 32'd4));
      chk("m_epc",      64'(epc),      64'(m.epc));
      chk("m_in_exc",   64'(in_exc),   64'(m.in_exc));
      chk("m_exc_lost", 64'(exc_lost), 64'(m.lost));
      chk("m_addr_err", 64'(addr_err), 64'(m.aerr));
    end
  end

  task automatic step(input logic wr, input logic [2:0] sel, input logic [31:0] rs = 32'h0,
                      input logic ex = 1'b0, input logic bt = 1'b0,
                      input logic [15:0] im = 16'h0, input logic [25:0] tg = 26'h0);
    pc_wr = wr; npc_sel = sel; rs_val = rs; exc_req = ex;
    br_taken = bt; imm16 = im; target26 = tg;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; pc_wr = 1'b0; npc_sel = 3'd0; br_taken = 1'b0; imm16 = 16'h0;
    target26 = 26'h0; rs_val = 32'h0; exc_req = 1'b0;
    pc_wr64 = 1'b0; sel64 = 3'd0; rs64 = 64'h0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("rst_pc", 64'(pc), 64'h3000);
    chk("rst_pc4", 64'(pc4), 64'h3004);
    chk("rst_epc", 64'(epc), 64'h0);
    chk("rst_flags", 64'({in_exc, exc_lost, addr_err}), 64'h0);

    // sequential stepping and hold
    step(1, 0); chk("seq1", 64'(pc), 64'h3004);
    step(1, 0); chk("seq2", 64'(pc), 64'h3008);
    step(1, 0); chk("seq3", 64'(pc), 64'h300C);
    step(0, 0); step(0, 0); chk("hold", 64'(pc), 64'h300C);

    // branch taken backward, not taken, jump
    step(1, 0); chk("to3010", 64'(pc), 64'h3010);
    step(1, 1, 0, 0, 1, 16'hFFFC); chk("br_taken", 64'(pc), 64'h3004);
    step(1, 3, 32'h3010); chk("jr3010", 64'(pc), 64'h3010);
    step(1, 1, 0, 0, 0, 16'hFFFC); chk("br_not", 64'(pc), 64'h3014);
    step(1, 2, 0, 0, 0, 16'h0, 26'h0000C40); chk("jump", 64'(pc), 64'h3100);

    // misaligned JR -> address-error exception
    step(1, 3, 32'h3020);
    step(1, 3, 32'h3402);
    chk("jrmis_pc", 64'(pc), 64'h4180);
    chk("jrmis_epc", 64'(epc), 64'h3020);
    chk("jrmis_inexc", 64'(in_exc), 64'h1);
    chk("jrmis_aerr", 64'(addr_err), 64'h1);
    step(0, 0); chk("aerr_pulse", 64'(addr_err), 64'h0);

    // handler: dropped exception, then ERET
    step(0, 0, 0, 1); chk("lost_pc", 64'(pc), 64'h4180);
    chk("lost_flag", 64'(exc_lost), 64'h1);
    step(1, 4); chk("eret_pc", 64'(pc), 64'h3020);
    chk("eret_inexc", 64'(in_exc), 64'h0);
    chk("eret_lost", 64'(exc_lost), 64'h1);

    // aligned JR in NORMAL, ERET in NORMAL, exception beats jump
    step(1, 3, 32'h3400); chk("jr_ok", 64'(pc), 64'h3400);
    chk("jr_ok_aerr", 64'(addr_err), 64'h0);
    step(1, 3, 32'h3000);
    step(1, 4); chk("eret_norm", 64'(pc), 64'h3004);
    chk("eret_norm_epc", 64'(epc), 64'h3020);
    step(1, 2, 0, 1, 0, 16'h0, 26'h0000C40);
    chk("exc_wins_pc", 64'(pc), 64'h4180);
    chk("exc_wins_epc", 64'(epc), 64'h3004);

    // misaligned JR inside handler holds PC; lone exc_req lets SEQ proceed
    step(1, 3, 32'h5001); chk("hjr_pc", 64'(pc), 64'h4180);
    chk("hjr_aerr", 64'(addr_err), 64'h1);
    step(1, 0, 0, 1); chk("hseq_exc", 64'(pc), 64'h4184);
    step(1, 0); chk("hseq", 64'(pc), 64'h4188);
    chk("h_in_exc", 64'(in_exc), 64'h1);

    // reset from HANDLER
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
    chk("rst2_pc", 64'(pc), 64'h3000);
    chk("rst2_state", 64'({in_exc, exc_lost}), 64'h0);
    chk("rst2_epc", 64'(epc), 64'h0);
    chk("w64_rst", pc_64, 64'h3000);

    // 64-bit wrap-around
    pc_wr64 = 1'b1; sel64 = 3'd3; rs64 = 64'hFFFF_FFFF_FFFF_FFFC;
    @(posedge clk); #2;
    chk("w64_load", pc_64, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("w64_pc4", pc4_64, 64'h0);
    sel64 = 3'd0;
    @(posedge clk); #2;
    chk("w64_wrap", pc_64, 64'h0);
    pc_wr64 = 1'b0;
    step(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
